// File: rtl/tl_buffer_queued.sv
// tl_buffer_queued: TileLink-UL buffer node with an independent FIFO on the
// A channel (in -> out) and on the D channel (out -> in). A channel depth of
// 0 turns that channel into a plain wire.
//
// Ports:
//   clock, reset          sole clock, synchronous active-high reset
//   auto_in_a_*           A channel from the client (enqueue side)
//   auto_out_a_*          A channel towards the manager (dequeue side)
//   auto_out_d_*          D channel from the manager (enqueue side)
//   auto_in_d_*           D channel towards the client (dequeue side)
//   a_count, d_count      queue occupancy, present only when
//                         TL_BUFFER_QUEUED_OCCUPANCY_EN is defined
//
// Optional feature macro: TL_BUFFER_QUEUED_OCCUPANCY_EN

module tl_buffer_queued_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 8,
  parameter int FLOW  = 0,
  parameter int PIPE  = 0,
  parameter int CNT_W = 2
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_enq_valid,
  output logic             o_enq_ready,
  input  logic [W-1:0]     i_enq_bits,
  output logic             o_deq_valid,
  input  logic             i_deq_ready,
  output logic [W-1:0]     o_deq_bits,
  output logic [CNT_W-1:0] o_count
);

  if (DEPTH == 0) begin : g_wire
    assign o_deq_valid = i_enq_valid;
    assign o_enq_ready = i_deq_ready;
    assign o_deq_bits  = i_enq_bits;
    assign o_count     = '0;
    // clock and reset have no function in a wire channel
    logic w_unused;
    assign w_unused = &{1'b0, i_clock, i_reset};
  end else begin : g_queue
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_rptr, r_wptr;
    logic [CNT_W-1:0] r_count;
    logic w_empty, w_full, w_enq_fire, w_deq_fire, w_bypass, w_push, w_pop;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FULL);

    // Outputs are forced idle while reset is high.
    assign o_enq_ready = !i_reset && (!w_full || ((PIPE != 0) && i_deq_ready));
    assign o_deq_valid = !i_reset && (!w_empty || ((FLOW != 0) && i_enq_valid));
    assign o_deq_bits  = ((FLOW != 0) && w_empty) ? i_enq_bits : r_mem[r_rptr];

    assign w_enq_fire = i_enq_valid && o_enq_ready;
    assign w_deq_fire = o_deq_valid && i_deq_ready;
    // A beat that flows straight through an empty queue never touches storage.
    assign w_bypass   = (FLOW != 0) && w_empty && w_deq_fire;
    assign w_push     = w_enq_fire && !w_bypass;
    assign w_pop      = w_deq_fire && !w_bypass;

    always_ff @(posedge i_clock) begin
      if (i_reset) begin
        r_rptr  <= '0;
        r_wptr  <= '0;
        r_count <= '0;
      end else begin
        if (w_push) r_wptr <= (r_wptr == LAST) ? '0 : r_wptr + PTR_W'(1);
        if (w_pop)  r_rptr <= (r_rptr == LAST) ? '0 : r_rptr + PTR_W'(1);
        if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
        else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
      end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge i_clock) begin
      if (w_push) r_mem[r_wptr] <= i_enq_bits;
    end

    assign o_count = r_count;
  end

endmodule

module tl_buffer_queued #(
  parameter int A_DEPTH = 2,
  parameter int D_DEPTH = 2,
  parameter int A_FLOW  = 0,
  parameter int D_FLOW  = 0,
  parameter int A_PIPE  = 0,
  parameter int D_PIPE  = 0,
  parameter int ADDR_W  = 15,
  parameter int SRC_W   = 5,
  parameter int DATA_W  = 64,
  localparam int A_CNT_W = (A_DEPTH == 0) ? 1 : $clog2(A_DEPTH + 1),
  localparam int D_CNT_W = (D_DEPTH == 0) ? 1 : $clog2(D_DEPTH + 1)
) (
  input  logic                clock,
  input  logic                reset,
`ifdef TL_BUFFER_QUEUED_OCCUPANCY_EN
  output logic [A_CNT_W-1:0]  a_count,
  output logic [D_CNT_W-1:0]  d_count,
`endif
  output logic                auto_in_a_ready,
  input  logic                auto_in_a_valid,
  input  logic [2:0]          auto_in_a_bits_opcode,
  input  logic [2:0]          auto_in_a_bits_param,
  input  logic [2:0]          auto_in_a_bits_size,
  input  logic [SRC_W-1:0]    auto_in_a_bits_source,
  input  logic [ADDR_W-1:0]   auto_in_a_bits_address,
  input  logic [DATA_W/8-1:0] auto_in_a_bits_mask,
  input  logic [DATA_W-1:0]   auto_in_a_bits_data,
  input  logic                auto_in_a_bits_corrupt,
  input  logic                auto_out_a_ready,
  output logic                auto_out_a_valid,
  output logic [2:0]          auto_out_a_bits_opcode,
  output logic [2:0]          auto_out_a_bits_param,
  output logic [2:0]          auto_out_a_bits_size,
  output logic [SRC_W-1:0]    auto_out_a_bits_source,
  output logic [ADDR_W-1:0]   auto_out_a_bits_address,
  output logic [DATA_W/8-1:0] auto_out_a_bits_mask,
  output logic [DATA_W-1:0]   auto_out_a_bits_data,
  output logic                auto_out_a_bits_corrupt,
  output logic                auto_out_d_ready,
  input  logic                auto_out_d_valid,
  input  logic [2:0]          auto_out_d_bits_opcode,
  input  logic [1:0]          auto_out_d_bits_param,
  input  logic [2:0]          auto_out_d_bits_size,
  input  logic [SRC_W-1:0]    auto_out_d_bits_source,
  input  logic                auto_out_d_bits_sink,
  input  logic                auto_out_d_bits_denied,
  input  logic [DATA_W-1:0]   auto_out_d_bits_data,
  input  logic                auto_out_d_bits_corrupt,
  input  logic                auto_in_d_ready,
  output logic                auto_in_d_valid,
  output logic [2:0]          auto_in_d_bits_opcode,
  output logic [1:0]          auto_in_d_bits_param,
  output logic [2:0]          auto_in_d_bits_size,
  output logic [SRC_W-1:0]    auto_in_d_bits_source,
  output logic                auto_in_d_bits_sink,
  output logic                auto_in_d_bits_denied,
  output logic [DATA_W-1:0]   auto_in_d_bits_data,
  output logic                auto_in_d_bits_corrupt
);

  localparam int AW = 9 + SRC_W + ADDR_W + DATA_W / 8 + DATA_W + 1;
  localparam int DW = 8 + SRC_W + 2 + DATA_W + 1;

  logic [AW-1:0] w_a_enq, w_a_deq;
  logic [DW-1:0] w_d_enq, w_d_deq;
  logic [A_CNT_W-1:0] w_a_count;
  logic [D_CNT_W-1:0] w_d_count;

  assign w_a_enq = {auto_in_a_bits_opcode, auto_in_a_bits_param, auto_in_a_bits_size,
                    auto_in_a_bits_source, auto_in_a_bits_address, auto_in_a_bits_mask,
                    auto_in_a_bits_data, auto_in_a_bits_corrupt};
  assign {auto_out_a_bits_opcode, auto_out_a_bits_param, auto_out_a_bits_size,
          auto_out_a_bits_source, auto_out_a_bits_address, auto_out_a_bits_mask,
          auto_out_a_bits_data, auto_out_a_bits_corrupt} = w_a_deq;

  assign w_d_enq = {auto_out_d_bits_opcode, auto_out_d_bits_param, auto_out_d_bits_size,
                    auto_out_d_bits_source, auto_out_d_bits_sink, auto_out_d_bits_denied,
                    auto_out_d_bits_data, auto_out_d_bits_corrupt};
  assign {auto_in_d_bits_opcode, auto_in_d_bits_param, auto_in_d_bits_size,
          auto_in_d_bits_source, auto_in_d_bits_sink, auto_in_d_bits_denied,
          auto_in_d_bits_data, auto_in_d_bits_corrupt} = w_d_deq;

  tl_buffer_queued_fifo #(
    .DEPTH(A_DEPTH), .W(AW), .FLOW(A_FLOW), .PIPE(A_PIPE), .CNT_W(A_CNT_W)
  ) u_a_queue (
    .i_clock     (clock),
    .i_reset     (reset),
    .i_enq_valid (auto_in_a_valid),
    .o_enq_ready (auto_in_a_ready),
    .i_enq_bits  (w_a_enq),
    .o_deq_valid (auto_out_a_valid),
    .i_deq_ready (auto_out_a_ready),
    .o_deq_bits  (w_a_deq),
    .o_count     (w_a_count)
  );

  tl_buffer_queued_fifo #(
    .DEPTH(D_DEPTH), .W(DW), .FLOW(D_FLOW), .PIPE(D_PIPE), .CNT_W(D_CNT_W)
  ) u_d_queue (
    .i_clock     (clock),
    .i_reset     (reset),
    .i_enq_valid (auto_out_d_valid),
    .o_enq_ready (auto_out_d_ready),
    .i_enq_bits  (w_d_enq),
    .o_deq_valid (auto_in_d_valid),
    .i_deq_ready (auto_in_d_ready),
    .o_deq_bits  (w_d_deq),
    .o_count     (w_d_count)
  );

`ifdef TL_BUFFER_QUEUED_OCCUPANCY_EN
  assign a_count = w_a_count;
  assign d_count = w_d_count;
`else
  logic w_unused_count;
  assign w_unused_count = &{1'b0, w_a_count, w_d_count};
`endif

endmodule

// File: tb/tb_tl_buffer_queued.sv
module tb_tl_buffer_queued;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  int n_assert = 0;
  int n_fail   = 0;

  // A beat packing: opcode[101:99] param[98:96] size[95:93] source[92:88]
  // address[87:73] mask[72:65] data[64:1] corrupt[0]
  // D beat packing: opcode[79:77] param[76:75] size[74:72] source[71:67]
  // sink[66] denied[65] data[64:1] corrupt[0]

  // p1: A depth 2, D depth 2 with FLOW
  logic p1_ia_ready, p1_ia_valid, p1_oa_ready, p1_oa_valid;
  logic p1_od_ready, p1_od_valid, p1_id_ready, p1_id_valid;
  logic [101:0] p1_ia_bits, p1_oa_bits;
  logic [79:0]  p1_od_bits, p1_id_bits;
  // p2: A depth 2 with PIPE, D depth 3
  logic p2_ia_ready, p2_ia_valid, p2_oa_ready, p2_oa_valid;
  logic p2_od_ready, p2_od_valid, p2_id_ready, p2_id_valid;
  logic [101:0] p2_ia_bits, p2_oa_bits;
  logic [79:0]  p2_od_bits, p2_id_bits;
  // p3: both channels depth 0
  logic p3_ia_ready, p3_ia_valid, p3_oa_ready, p3_oa_valid;
  logic p3_od_ready, p3_od_valid, p3_id_ready, p3_id_valid;
  logic [101:0] p3_ia_bits, p3_oa_bits;
  logic [79:0]  p3_od_bits, p3_id_bits;
`ifdef TL_BUFFER_QUEUED_OCCUPANCY_EN
  logic [1:0] p1_a_count, p1_d_count, p2_a_count, p2_d_count;
  logic       p3_a_count, p3_d_count;
`endif

  tl_buffer_queued #(.A_DEPTH(2), .D_DEPTH(2), .D_FLOW(1)) dut1 (
    .clock(clock), .reset(reset),
`ifdef TL_BUFFER_QUEUED_OCCUPANCY_EN
    .a_count(p1_a_count), .d_count(p1_d_count),
`endif
    .auto_in_a_ready(p1_ia_ready), .auto_in_a_valid(p1_ia_valid),
    .auto_in_a_bits_opcode(p1_ia_bits[101:99]), .auto_in_a_bits_param(p1_ia_bits[98:96]),
    .auto_in_a_bits_size(p1_ia_bits[95:93]), .auto_in_a_bits_source(p1_ia_bits[92:88]),
    .auto_in_a_bits_address(p1_ia_bits[87:73]), .auto_in_a_bits_mask(p1_ia_bits[72:65]),
    .auto_in_a_bits_data(p1_ia_bits[64:1]), .auto_in_a_bits_corrupt(p1_ia_bits[0]),
    .auto_out_a_ready(p1_oa_ready), .auto_out_a_valid(p1_oa_valid),
    .auto_out_a_bits_opcode(p1_oa_bits[101:99]), .auto_out_a_bits_param(p1_oa_bits[98:96]),
    .auto_out_a_bits_size(p1_oa_bits[95:93]), .auto_out_a_bits_source(p1_oa_bits[92:88]),
    .auto_out_a_bits_address(p1_oa_bits[87:73]), .auto_out_a_bits_mask(p1_oa_bits[72:65]),
    .auto_out_a_bits_data(p1_oa_bits[64:1]), .auto_out_a_bits_corrupt(p1_oa_bits[0]),
    .auto_out_d_ready(p1_od_ready), .auto_out_d_valid(p1_od_valid),
    .auto_out_d_bits_opcode(p1_od_bits[79:77]), .auto_out_d_bits_param(p1_od_bits[76:75]),
    .auto_out_d_bits_size(p1_od_bits[74:72]), .auto_out_d_bits_source(p1_od_bits[71:67]),
    .auto_out_d_bits_sink(p1_od_bits[66]), .auto_out_d_bits_denied(p1_od_bits[65]),
    .auto_out_d_bits_data(p1_od_bits[64:1]), .auto_out_d_bits_corrupt(p1_od_bits[0]),
    .auto_in_d_ready(p1_id_ready), .auto_in_d_valid(p1_id_valid),
    .auto_in_d_bits_opcode(p1_id_bits[79:77]), .auto_in_d_bits_param(p1_id_bits[76:75]),
    .auto_in_d_bits_size(p1_id_bits[74:72]), .auto_in_d_bits_source(p1_id_bits[71:67]),
    .auto_in_d_bits_sink(p1_id_bits[66]), .auto_in_d_bits_denied(p1_id_bits[65]),
    .auto_in_d_bits_data(p1_id_bits[64:1]), .auto_in_d_bits_corrupt(p1_id_bits[0])
  );

  tl_buffer_queued #(.A_DEPTH(2), .A_PIPE(1), .D_DEPTH(3)) dut2 (
    .clock(clock), .reset(reset),
`ifdef TL_BUFFER_QUEUED_OCCUPANCY_EN
    .a_count(p2_a_count), .d_count(p2_d_count),
`endif
    .auto_in_a_ready(p2_ia_ready), .auto_in_a_valid(p2_ia_valid),
    .auto_in_a_bits_opcode(p2_ia_bits[101:99]), .auto_in_a_bits_param(p2_ia_bits[98:96]),
    .auto_in_a_bits_size(p2_ia_bits[95:93]), .auto_in_a_bits_source(p2_ia_bits[92:88]),
    .auto_in_a_bits_address(p2_ia_bits[87:73]), .auto_in_a_bits_mask(p2_ia_bits[72:65]),
    .auto_in_a_bits_data(p2_ia_bits[64:1]), .auto_in_a_bits_corrupt(p2_ia_bits[0]),
    .auto_out_a_ready(p2_oa_ready), .auto_out_a_valid(p2_oa_valid),
    .auto_out_a_bits_opcode(p2_oa_bits[101:99]), .auto_out_a_bits_param(p2_oa_bits[98:96]),
    .auto_out_a_bits_size(p2_oa_bits[95:93]), .auto_out_a_bits_source(p2_oa_bits[92:88]),
    .auto_out_a_bits_address(p2_oa_bits[87:73]), .auto_out_a_bits_mask(p2_oa_bits[72:65]),
    .auto_out_a_bits_data(p2_oa_bits[64:1]), .auto_out_a_bits_corrupt(p2_oa_bits[0]),
    .auto_out_d_ready(p2_od_ready), .auto_out_d_valid(p2_od_valid),
    .auto_out_d_bits_opcode(p2_od_bits[79:77]), .auto_out_d_bits_param(p2_od_bits[76:75]),
    .auto_out_d_bits_size(p2_od_bits[74:72]), .auto_out_d_bits_source(p2_od_bits[71:67]),
    .auto_out_d_bits_sink(p2_od_bits[66]), .auto_out_d_bits_denied(p2_od_bits[65]),
    .auto_out_d_bits_data(p2_od_bits[64:1]), .auto_out_d_bits_corrupt(p2_od_bits[0]),
    .auto_in_d_ready(p2_id_ready), .auto_in_d_valid(p2_id_valid),
    .auto_in_d_bits_opcode(p2_id_bits[79:77]), .auto_in_d_bits_param(p2_id_bits[76:75]),
    .auto_in_d_bits_size(p2_id_bits[74:72]), .auto_in_d_bits_source(p2_id_bits[71:67]),
    .auto_in_d_bits_sink(p2_id_bits[66]), .auto_in_d_bits_denied(p2_id_bits[65]),
    .auto_in_d_bits_data(p2_id_bits[64:1]), .auto_in_d_bits_corrupt(p2_id_bits[0])
  );

  tl_buffer_queued #(.A_DEPTH(0), .D_DEPTH(0)) dut3 (
    .clock(clock), .reset(reset),
`ifdef TL_BUFFER_QUEUED_OCCUPANCY_EN
    .a_count(p3_a_count), .d_count(p3_d_count),
`endif
    .auto_in_a_ready(p3_ia_ready), .auto_in_a_valid(p3_ia_valid),
    .auto_in_a_bits_opcode(p3_ia_bits[101:99]), .auto_in_a_bits_param(p3_ia_bits[98:96]),
    .auto_in_a_bits_size(p3_ia_bits[95:93]), .auto_in_a_bits_source(p3_ia_bits[92:88]),
    .auto_in_a_bits_address(p3_ia_bits[87:73]), .auto_in_a_bits_mask(p3_ia_bits[72:65]),
    .auto_in_a_bits_data(p3_ia_bits[64:1]), .auto_in_a_bits_corrupt(p3_ia_bits[0]),
    .auto_out_a_ready(p3_oa_ready), .auto_out_a_valid(p3_oa_valid),
    .auto_out_a_bits_opcode(p3_oa_bits[101:99]), .auto_out_a_bits_param(p3_oa_bits[98:96]),
    .auto_out_a_bits_size(p3_oa_bits[95:93]), .auto_out_a_bits_source(p3_oa_bits[92:88]),
    .auto_out_a_bits_address(p3_oa_bits[87:73]), .auto_out_a_bits_mask(p3_oa_bits[72:65]),
    .auto_out_a_bits_data(p3_oa_bits[64:1]), .auto_out_a_bits_corrupt(p3_oa_bits[0]),
    .auto_out_d_ready(p3_od_ready), .auto_out_d_valid(p3_od_valid),
    .auto_out_d_bits_opcode(p3_od_bits[79:77]), .auto_out_d_bits_param(p3_od_bits[76:75]),
    .auto_out_d_bits_size(p3_od_bits[74:72]), .auto_out_d_bits_source(p3_od_bits[71:67]),
    .auto_out_d_bits_sink(p3_od_bits[66]), .auto_out_d_bits_denied(p3_od_bits[65]),
    .auto_out_d_bits_data(p3_od_bits[64:1]), .auto_out_d_bits_corrupt(p3_od_bits[0]),
    .auto_in_d_ready(p3_id_ready), .auto_in_d_valid(p3_id_valid),
    .auto_in_d_bits_opcode(p3_id_bits[79:77]), .auto_in_d_bits_param(p3_id_bits[76:75]),
    .auto_in_d_bits_size(p3_id_bits[74:72]), .auto_in_d_bits_source(p3_id_bits[71:67]),
    .auto_in_d_bits_sink(p3_id_bits[66]), .auto_in_d_bits_denied(p3_id_bits[65]),
    .auto_in_d_bits_data(p3_id_bits[64:1]), .auto_in_d_bits_corrupt(p3_id_bits[0])
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [101:0] mk_a(input logic [4:0] src);
    logic [101:0] v;
    v = '0;
    v[101:99] = 3'd4;
    v[95:93]  = 3'd3;
    v[92:88]  = src;
    v[87:73]  = 15'h0100 + 15'(src);
    v[72:65]  = 8'hFF;
    v[64:1]   = {32'hCAFE_0000, 27'd0, src};
    v[0]      = src[0];
    return v;
  endfunction

  function automatic logic [79:0] mk_d(input logic [63:0] data);
    logic [79:0] v;
    v = '0;
    v[79:77] = 3'd1;
    v[74:72] = 3'd3;
    v[71:67] = 5'd9;
    v[65]    = 1'b1;
    v[64:1]  = data;
    v[0]     = 1'b1;
    return v;
  endfunction

  localparam int N_BEATS = 3000;
  localparam int MAX_CYC = 40000;

  logic [79:0] sb[$];
  logic [79:0] held_bits, exp_bits, d2;
  logic        stall_prev, enq_fired;
  int          sent, got, cycles;

  initial begin
    reset = 1'b1;
    p1_ia_valid = 0; p1_oa_ready = 0; p1_od_valid = 0; p1_id_ready = 0;
    p2_ia_valid = 0; p2_oa_ready = 0; p2_od_valid = 0; p2_id_ready = 0;
    p3_ia_valid = 0; p3_oa_ready = 0; p3_od_valid = 0; p3_id_ready = 0;
    p1_ia_bits = '0; p1_od_bits = '0; p2_ia_bits = '0; p2_od_bits = '0;
    p3_ia_bits = '0; p3_od_bits = '0;
    repeat (3) step();

    chk("rst_in_a_ready", 128'(p1_ia_ready), 128'(0));
    chk("rst_out_a_valid", 128'(p1_oa_valid), 128'(0));
    chk("rst_out_d_ready", 128'(p1_od_ready), 128'(0));
    reset = 1'b0;
    #1;
    chk("post_rst_in_a_ready", 128'(p1_ia_ready), 128'(1));
    chk("post_rst_out_a_valid", 128'(p1_oa_valid), 128'(0));
`ifdef TL_BUFFER_QUEUED_OCCUPANCY_EN
    chk("post_rst_a_count", 128'(p1_a_count), 128'(0));
`endif

    // Depth 2, FLOW=0, PIPE=0 fill then drain
    p1_ia_valid = 1; p1_ia_bits = mk_a(1); #1;
    chk("t1_c0_in_ready", 128'(p1_ia_ready), 128'(1));
    chk("t1_c0_out_valid", 128'(p1_oa_valid), 128'(0));
    step();
    p1_ia_bits = mk_a(2); #1;
    chk("t1_c1_in_ready", 128'(p1_ia_ready), 128'(1));
    chk("t1_c1_out_valid", 128'(p1_oa_valid), 128'(1));
    chk("t1_c1_out_bits", 128'(p1_oa_bits), 128'(mk_a(1)));
    step();
    p1_ia_bits = mk_a(3); #1;
    chk("t1_c2_in_ready_full", 128'(p1_ia_ready), 128'(0));
    chk("t1_c2_out_src", 128'(p1_oa_bits[92:88]), 128'(1));
`ifdef TL_BUFFER_QUEUED_OCCUPANCY_EN
    chk("t1_c2_a_count", 128'(p1_a_count), 128'(2));
`endif
    step();
    p1_oa_ready = 1; #1;
    chk("t1_c3_in_ready_nopipe", 128'(p1_ia_ready), 128'(0));
    chk("t1_c3_out_bits", 128'(p1_oa_bits), 128'(mk_a(1)));
    step();
    chk("t1_c4_in_ready", 128'(p1_ia_ready), 128'(1));
    chk("t1_c4_out_bits", 128'(p1_oa_bits), 128'(mk_a(2)));
    step();
    p1_ia_valid = 0; #1;
    chk("t1_c5_out_valid", 128'(p1_oa_valid), 128'(1));
    chk("t1_c5_out_bits", 128'(p1_oa_bits), 128'(mk_a(3)));
    step();
    chk("t1_c6_out_valid", 128'(p1_oa_valid), 128'(0));
    p1_oa_ready = 0;

    // Same stimulus with PIPE=1: full queue keeps accepting
    p2_ia_valid = 1; p2_ia_bits = mk_a(1); #1;
    chk("t2_c0_in_ready", 128'(p2_ia_ready), 128'(1));
    step();
    p2_ia_bits = mk_a(2); #1;
    chk("t2_c1_in_ready", 128'(p2_ia_ready), 128'(1));
    step();
    p2_ia_bits = mk_a(3); p2_oa_ready = 1; #1;
    chk("t2_c2_in_ready_pipe", 128'(p2_ia_ready), 128'(1));
    chk("t2_c2_out_bits", 128'(p2_oa_bits), 128'(mk_a(1)));
`ifdef TL_BUFFER_QUEUED_OCCUPANCY_EN
    chk("t2_c2_a_count", 128'(p2_a_count), 128'(2));
`endif
    step();
    p2_ia_bits = mk_a(4); #1;
    chk("t2_c3_in_ready_pipe", 128'(p2_ia_ready), 128'(1));
    chk("t2_c3_out_bits", 128'(p2_oa_bits), 128'(mk_a(2)));
`ifdef TL_BUFFER_QUEUED_OCCUPANCY_EN
    chk("t2_c3_a_count", 128'(p2_a_count), 128'(2));
`endif
    step();
    p2_ia_valid = 0; #1;
    chk("t2_c4_out_bits", 128'(p2_oa_bits), 128'(mk_a(3)));
    step();
    chk("t2_c5_out_bits", 128'(p2_oa_bits), 128'(mk_a(4)));
    step();
    chk("t2_c6_out_valid", 128'(p2_oa_valid), 128'(0));
    p2_oa_ready = 0;

    // D FLOW=1 bypass when empty
    p1_id_ready = 1; p1_od_valid = 1; p1_od_bits = mk_d(64'hDEADBEEF_00000001); #1;
    chk("t3_flow_valid", 128'(p1_id_valid), 128'(1));
    chk("t3_flow_bits", 128'(p1_id_bits), 128'(mk_d(64'hDEADBEEF_00000001)));
    chk("t3_flow_ready", 128'(p1_od_ready), 128'(1));
    step();
    p1_od_valid = 0; #1;
    chk("t3_not_stored", 128'(p1_id_valid), 128'(0));
`ifdef TL_BUFFER_QUEUED_OCCUPANCY_EN
    chk("t3_d_count", 128'(p1_d_count), 128'(0));
`endif
    // bypassed beat that is not taken must be stored
    p1_id_ready = 0; p1_od_valid = 1; p1_od_bits = mk_d(64'h0123_4567_89AB_CDEF); #1;
    chk("t3_flow_stall_valid", 128'(p1_id_valid), 128'(1));
    step();
    p1_od_valid = 0; #1;
    chk("t3_stored_valid", 128'(p1_id_valid), 128'(1));
    chk("t3_stored_bits", 128'(p1_id_bits), 128'(mk_d(64'h0123_4567_89AB_CDEF)));
    p1_id_ready = 1;
    step();
    chk("t3_drained", 128'(p1_id_valid), 128'(0));

    // Depth 0 on both channels: pure wires
    for (int i = 0; i < 8; i++) begin
      p3_ia_bits  = 102'({$urandom(), $urandom(), $urandom(), $urandom()});
      p3_od_bits  = 80'({$urandom(), $urandom(), $urandom()});
      p3_ia_valid = 1'($urandom_range(0, 1));
      p3_oa_ready = 1'($urandom_range(0, 1));
      p3_od_valid = 1'($urandom_range(0, 1));
      p3_id_ready = 1'($urandom_range(0, 1));
      #1;
      chk("t4_a_bits", 128'(p3_oa_bits), 128'(p3_ia_bits));
      chk("t4_a_valid", 128'(p3_oa_valid), 128'(p3_ia_valid));
      chk("t4_a_ready", 128'(p3_ia_ready), 128'(p3_oa_ready));
      chk("t4_d_bits", 128'(p3_id_bits), 128'(p3_od_bits));
      chk("t4_d_valid", 128'(p3_id_valid), 128'(p3_od_valid));
      chk("t4_d_ready", 128'(p3_od_ready), 128'(p3_id_ready));
      step();
    end

    // Reset with two A beats queued
    p1_oa_ready = 0; p1_ia_valid = 1; p1_ia_bits = mk_a(5);
    step();
    p1_ia_bits = mk_a(6);
    step();
    p1_ia_valid = 0; #1;
    chk("t5_queued_valid", 128'(p1_oa_valid), 128'(1));
    reset = 1; #1;
    chk("t5_rst_in_ready", 128'(p1_ia_ready), 128'(0));
    chk("t5_rst_out_valid", 128'(p1_oa_valid), 128'(0));
    step();
    reset = 0; #1;
    chk("t5_after_out_valid", 128'(p1_oa_valid), 128'(0));
    chk("t5_after_in_ready", 128'(p1_ia_ready), 128'(1));
`ifdef TL_BUFFER_QUEUED_OCCUPANCY_EN
    chk("t5_after_a_count", 128'(p1_a_count), 128'(0));
`endif
    p1_ia_valid = 1; p1_ia_bits = mk_a(7);
    step();
    p1_ia_valid = 0; #1;
    chk("t5_first_out_bits", 128'(p1_oa_bits), 128'(mk_a(7)));
    p1_oa_ready = 1;
    step();
    chk("t5_empty_again", 128'(p1_oa_valid), 128'(0));
    p1_oa_ready = 0;

    // Random stalls through the depth-3 D queue with a scoreboard
    sent = 0; got = 0; cycles = 0; stall_prev = 0; held_bits = '0;
    while (got < N_BEATS && cycles < MAX_CYC) begin
      if (!p2_od_valid && sent < N_BEATS && $urandom_range(0, 3) != 0) begin
        p2_od_valid = 1;
        d2 = 80'({$urandom(), $urandom(), $urandom()});
        p2_od_bits = d2;
      end
      p2_id_ready = ($urandom_range(0, 3) != 0);
      #1;
      chk("t6_deq_valid", 128'(p2_id_valid), 128'(sb.size() != 0));
      chk("t6_enq_ready", 128'(p2_od_ready), 128'(sb.size() != 3));
      if (stall_prev) chk("t6_stable_bits", 128'(p2_id_bits), 128'(held_bits));
      if (p2_id_valid && p2_id_ready && sb.size() != 0) begin
        exp_bits = sb.pop_front();
        chk("t6_order", 128'(p2_id_bits), 128'(exp_bits));
        got++;
      end
      stall_prev = p2_id_valid && !p2_id_ready;
      held_bits  = p2_id_bits;
      enq_fired  = p2_od_valid && p2_od_ready;
      if (enq_fired) begin
        sb.push_back(p2_od_bits);
        sent++;
      end
      step();
      if (enq_fired) p2_od_valid = 0;
      cycles++;
    end
    chk("t6_beats_received", 128'(got), 128'(N_BEATS));
    chk("t6_scoreboard_empty", 128'(sb.size()), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
